quad_updown_decoder: RTL and testbench
======================================

// Module: quad_updown_decoder
// PURPOSE
//   Quadrature (A/B) decoder that turns two asynchronous encoder phases into
//   single-cycle up/down strobes driving the mod-N up/down position counter.
//   Synchronises, glitch-filters and Gray-decodes the phases and flags illegal
//   two-bit jumps. It sits between the encoder pins and the counter's up/down inputs.
// PARAMETERS
//   FILT_LEN  3  consecutive stable synced cycles required to accept a new A/B state (1..15)
//   MODE      4  strobes per Gray cycle: 4 = every edge, 2 = entry to 00/11, 1 = entry to 00
// PORTS
//   clk       in   1  system clock, all state on rising edge
//   reset_n   in   1  asynchronous, active-low reset
//   enc_a     in   1  encoder phase A, asynchronous to clk
//   enc_b     in   1  encoder phase B, asynchronous to clk
//   en        in   1  strobe enable; filter/decoder keep tracking when low
//   clr_err   in   1  synchronous clear of err_cnt
//   up        out  1  one-cycle count-up strobe
//   down      out  1  one-cycle count-down strobe
//   dir       out  1  last accepted direction: 1 = up, 0 = down
//   err       out  1  one-cycle strobe on an illegal transition
//   err_cnt   out  8  saturating count of illegal transitions
// BEHAVIOUR
//   Reset (reset_n low, async): sync flops, filter state ab_f, filter counter,
//     primed, up, down, err and dir = 0; err_cnt = 8'd0. All outputs low.
//   Sync: {enc_a,enc_b} pass through 2 FF stages -> s[1:0]. No other logic before stage 2.
//   Filter: cand holds the last s value; cnt resets to 0 whenever s != cand.
//     When s == cand != ab_f for FILT_LEN consecutive cycles, ab_f <= cand
//     (an "accept"). Any bounce shorter than FILT_LEN is discarded.
//   Priming: the first accept after reset loads ab_f and sets primed without
//     decoding. Before primed: no up/down/err. If the first synced value equals
//     ab_f (00), primed is set after FILT_LEN stable cycles with no strobe.
//   Decode on accept (old = ab_f, new = cand), all outputs registered:
//     up sequence 00->01->11->10->00. Reverse = down. Both bits changed = illegal.
//   MODE 4: every legal accept strobes. MODE 2: strobe only when new is 00 or 11.
//     MODE 1: strobe only when new is 00 (10->00 up, 01->00 down).
//   dir updates on every legal accept, even if MODE or en suppresses the strobe.
//   en low: up/down forced 0. err and err_cnt still operate.
//   up and down are never high in the same cycle. Each strobe lasts exactly 1 cycle.
//   Latency: FILT_LEN+3 rising edges from the first edge that samples the new pin
//     level to the edge that asserts the strobe (2 sync + FILT_LEN filter + 1 decode).
//   Illegal jump: err = 1 for 1 cycle; ab_f takes the new value; no up/down;
//     dir unchanged; err_cnt += 1, saturating at 255.
//   clr_err and a new error in the same cycle: err_cnt = 1. clr_err alone: err_cnt = 0.
//   Max legal input rate: one phase change per FILT_LEN+1 cycles. Faster input
//     is filtered or counted as an error; this is not a functional failure.
//   Reset mid-operation: everything returns to reset values and priming repeats.
//     No strobe is emitted for the state present at reset release.
// TESTING
//   1. Reset release, pins held 11, FILT_LEN=3 -> primed after 5 cycles, no strobes, err_cnt=0.
//   2. MODE 4, forward 00->01->11->10->00, 20 cycles per step -> 4 up pulses, dir=1, each
//      up exactly FILT_LEN+3=6 edges after the pin change.
//   3. MODE 1, two full reverse cycles -> exactly 2 down pulses on entry to 00. MODE 2 -> 4 down pulses.
//   4. A/B 2-cycle glitch 00->01->00 with FILT_LEN=3 -> no strobe, ab_f stays 00.
//   5. Jump 00->11 -> err 1 cycle, err_cnt=1, no up/down. 300 jumps -> err_cnt=255.
//      clr_err on the same cycle as an err -> err_cnt=1.
//   6. en=0 during 3 forward steps -> no up, dir=1. Reset asserted mid-step -> outputs 0, re-prime.

Source files
------------

// File: rtl/quad_updown_decoder.sv
// quad_updown_decoder
//
// Quadrature A/B decoder. The two encoder phases are synchronised into the clk
// domain, glitch-filtered, and Gray-decoded into single-cycle up/down strobes
// for a downstream up/down position counter. Illegal two-bit jumps are flagged
// and counted.
//
// Parameters
//   FILT_LEN  consecutive stable synced cycles needed to accept a new A/B state (1..15)
//   MODE      strobes per Gray cycle: 4 = every edge, 2 = entry to 00/11, 1 = entry to 00
//
// Ports
//   clk       system clock, all state on rising edge
//   reset_n   asynchronous active-low reset
//   enc_a     encoder phase A (asynchronous)
//   enc_b     encoder phase B (asynchronous)
//   en        strobe enable; filter and decoder keep tracking when low
//   clr_err   synchronous clear of err_cnt
//   up        one-cycle count-up strobe
//   down      one-cycle count-down strobe
//   dir       last accepted direction, 1 = up, 0 = down
//   err       one-cycle strobe on an illegal transition
//   err_cnt   saturating count of illegal transitions

module quad_updown_decoder #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned MODE     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       en,
  input  logic       clr_err,
  output logic       up,
  output logic       down,
  output logic       dir,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] CntMax = 4'(FILT_LEN - 1);

  // Gray code to linear position: 00->0, 01->1, 11->2, 10->3.
  function automatic logic [1:0] gray2pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  // Synchroniser: nothing but flops ahead of stage 2.
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
    end
  end

  // State
  logic [1:0] vld_q, vld_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ab_f_q, ab_f_d;
  logic       primed_q, primed_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Decode signals
  logic       stable;
  logic       accept;
  logic       decode;
  logic [1:0] step;
  logic       is_up, is_dn, illegal;
  logic       mode_ok;

  // Filter: count consecutive cycles the synced value equals the candidate.
  // vld_q holds counting off until the synchroniser holds real pin samples,
  // so the reset contents of the sync flops can never prime the filter.
  always_comb begin
    vld_d  = {vld_q[0], 1'b1};
    cand_d = sync2_q;
    stable = (sync2_q == cand_q);
    cnt_d  = cnt_q;
    if (!stable) begin
      cnt_d = 4'd0;
    end else if (vld_q[1] && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 4'd1;
    end
    // The current stable cycle plus cnt_q earlier ones make FILT_LEN.
    accept = stable && vld_q[1] && (cnt_q == CntMax) &&
             (!primed_q || (cand_q != ab_f_q));
  end

  // Strobe filter by MODE, evaluated on the new (accepted) state.
  always_comb begin
    if (MODE == 32'd1) begin
      mode_ok = (cand_q == 2'b00);
    end else if (MODE == 32'd2) begin
      mode_ok = (cand_q[1] == cand_q[0]);
    end else begin
      mode_ok = 1'b1;
    end
  end

  // Decoder and error counter
  always_comb begin
    step    = gray2pos(cand_q) - gray2pos(ab_f_q);
    is_up   = (step == 2'd1);
    is_dn   = (step == 2'd3);
    illegal = (step == 2'd2);
    // The first accept after reset only establishes the reference state.
    decode  = accept && primed_q;

    ab_f_d   = accept ? cand_q : ab_f_q;
    primed_d = primed_q | accept;

    up_d   = decode && is_up && mode_ok && en;
    down_d = decode && is_dn && mode_ok && en;
    err_d  = decode && illegal;

    dir_d = dir_q;
    if (decode && (is_up || is_dn)) begin
      dir_d = is_up;
    end

    err_cnt_d = err_cnt_q;
    if (clr_err) begin
      err_cnt_d = {7'd0, err_d};
    end else if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q     <= 2'b00;
      cand_q    <= 2'b00;
      cnt_q     <= 4'd0;
      ab_f_q    <= 2'b00;
      primed_q  <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      vld_q     <= vld_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      ab_f_q    <= ab_f_d;
      primed_q  <= primed_d;
      up_q      <= up_d;
      down_q    <= down_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign up      = up_q;
  assign down    = down_q;
  assign dir     = dir_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Bench for quad_updown_decoder. The main instance (MODE 4) is checked against
// a scoreboard of expected strobes with exact arrival cycles; MODE 1 and MODE 2
// instances share the same pins and their pulses are counted.

module tb_quad_updown_decoder;

  localparam int unsigned FiltLen = 3;
  localparam int          Lat     = FiltLen + 3;
  localparam int          Hold    = 20;

  typedef struct {
    int kind;  // 0 up, 1 down, 2 err
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       en = 1'b1;
  logic       clr_err = 1'b0;
  logic       up, down, dir, err;
  logic [7:0] err_cnt;
  logic       m1_up, m1_down, m1_dir, m1_err;
  logic [7:0] m1_err_cnt;
  logic       m2_up, m2_down, m2_dir, m2_err;
  logic [7:0] m2_err_cnt;

  int cyc = 0;
  int m1_up_n = 0, m1_dn_n = 0, m2_up_n = 0, m2_dn_n = 0;

  int   nvec = 0;
  int   nerr = 0;
  ev_t  sb[$];
  logic [1:0] m_ab;
  logic       m_dir;
  int         m_errcnt;

  quad_updown_decoder #(.FILT_LEN(FiltLen), .MODE(4)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .clr_err(clr_err), .up(up), .down(down), .dir(dir), .err(err), .err_cnt(err_cnt)
  );

  quad_updown_decoder #(.FILT_LEN(FiltLen), .MODE(1)) dut_m1 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .clr_err(clr_err), .up(m1_up), .down(m1_down), .dir(m1_dir), .err(m1_err),
    .err_cnt(m1_err_cnt)
  );

  quad_updown_decoder #(.FILT_LEN(FiltLen), .MODE(2)) dut_m2 (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .clr_err(clr_err), .up(m2_up), .down(m2_down), .dir(m2_dir), .err(m2_err),
    .err_cnt(m2_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m1_up)   m1_up_n <= m1_up_n + 1;
    if (m1_down) m1_dn_n <= m1_dn_n + 1;
    if (m2_up)   m2_up_n <= m2_up_n + 1;
    if (m2_down) m2_dn_n <= m2_dn_n + 1;
  end

  function automatic logic [1:0] pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Advance to the next falling edge and pop/compare any strobe seen there.
  task automatic sample_cycle();
    int  okind;
    ev_t ev;
    @(negedge clk);
    if (up && down) begin
      nvec++;
      nerr++;
      $display("FAIL up_down_overlap: both high at cycle %0d, required exclusive", cyc);
    end
    if (up || down || err) begin
      nvec++;
      okind = err ? 2 : (down ? 1 : 0);
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL strobe_unexpected: kind %0d at cycle %0d, required none", okind, cyc);
      end else begin
        ev = sb.pop_front();
        if (okind !== ev.kind || cyc !== ev.cyc) begin
          nerr++;
          $display("FAIL strobe_scoreboard: kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   okind, cyc, ev.kind, ev.cyc);
        end
      end
    end
  endtask

  // Drive a new pin state at a falling edge and queue the expected result.
  task automatic step(input logic [1:0] ab, input int hold);
    logic [1:0] d;
    ev_t        ev;
    d = pos(ab) - pos(m_ab);
    enc_a = ab[1];
    enc_b = ab[0];
    ev.cyc = cyc + Lat;
    if (d == 2'd2) begin
      ev.kind = 2;
      sb.push_back(ev);
      if (m_errcnt < 255) m_errcnt++;
    end else if (d == 2'd1) begin
      m_dir = 1'b1;
      ev.kind = 0;
      if (en) sb.push_back(ev);
    end else if (d == 2'd3) begin
      m_dir = 1'b0;
      ev.kind = 1;
      if (en) sb.push_back(ev);
    end
    m_ab = ab;
    repeat (hold) sample_cycle();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (3) sample_cycle();
    nvec++;
    if ({up, down, err, dir} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_outputs: got %b, required 0000", {up, down, err, dir});
    end
    nvec++;
    if (err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
    end
    reset_n = 1'b1;
    m_ab = 2'b11;
    m_dir = 1'b0;
    m_errcnt = 0;
    sb.delete();
    repeat (Hold) sample_cycle();
    nvec++;
    if (err_cnt !== 8'd0 || dir !== 1'b0) begin
      nerr++;
      $display("FAIL prime_quiet: got err_cnt %0d dir %b, required 0 0", err_cnt, dir);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) step(fwd(m_ab), Hold);
    nvec++;
    if (dir !== m_dir) begin
      nerr++;
      $display("FAIL forward_dir: got %b, required %b", dir, m_dir);
    end
    nvec++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL forward_missing: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_modes();
    int u1, d1, u2, d2;
    u1 = m1_up_n; d1 = m1_dn_n; u2 = m2_up_n; d2 = m2_dn_n;
    for (int i = 0; i < 8; i++) step(rev(m_ab), Hold);
    nvec++;
    if (m1_dn_n - d1 !== 2 || m1_up_n - u1 !== 0) begin
      nerr++;
      $display("FAIL mode1_count: got down %0d up %0d, required 2 0", m1_dn_n - d1, m1_up_n - u1);
    end
    nvec++;
    if (m2_dn_n - d2 !== 4 || m2_up_n - u2 !== 0) begin
      nerr++;
      $display("FAIL mode2_count: got down %0d up %0d, required 4 0", m2_dn_n - d2, m2_up_n - u2);
    end
    nvec++;
    if (dir !== m_dir || sb.size() !== 0) begin
      nerr++;
      $display("FAIL mode4_reverse: got dir %b pending %0d, required %b 0", dir, sb.size(), m_dir);
    end
  endtask

  task automatic test_glitch();
    step(fwd(m_ab), Hold);
    step(fwd(m_ab), Hold);  // now at 00
    enc_a = 1'b0;
    enc_b = 1'b1;
    repeat (2) sample_cycle();
    enc_b = 1'b0;
    repeat (Hold) sample_cycle();
    nvec++;
    if (dir !== m_dir || err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL glitch_state: got dir %b err_cnt %0d, required %b 0", dir, err_cnt, m_dir);
    end
    // An up here proves the filtered state stayed at 00.
    step(2'b01, Hold);
    step(2'b00, Hold);
    nvec++;
    if (sb.size() !== 0 || dir !== m_dir) begin
      nerr++;
      $display("FAIL glitch_followup: got pending %0d dir %b, required 0 %b",
               sb.size(), dir, m_dir);
    end
  endtask

  task automatic test_errors();
    step(2'b11, Hold);
    nvec++;
    if (err_cnt !== 8'(m_errcnt) || dir !== m_dir) begin
      nerr++;
      $display("FAIL err_first: got err_cnt %0d dir %b, required %0d %b",
               err_cnt, dir, m_errcnt, m_dir);
    end
    for (int i = 0; i < 300; i++) step(m_ab ^ 2'b11, Lat);
    repeat (Hold) sample_cycle();
    nvec++;
    if (err_cnt !== 8'd255 || m_errcnt !== 255) begin
      nerr++;
      $display("FAIL err_saturate: got %0d, required 255", err_cnt);
    end
    nvec++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL err_missing: got %0d pending, required 0", sb.size());
    end
    // clr_err held through the edge that raises err.
    step(m_ab ^ 2'b11, 0);
    clr_err = 1'b1;
    repeat (Lat) sample_cycle();
    clr_err = 1'b0;
    m_errcnt = 1;
    nvec++;
    if (err_cnt !== 8'(m_errcnt)) begin
      nerr++;
      $display("FAIL clr_with_err: got %0d, required %0d", err_cnt, m_errcnt);
    end
    repeat (Hold) sample_cycle();
    clr_err = 1'b1;
    sample_cycle();
    clr_err = 1'b0;
    m_errcnt = 0;
    nvec++;
    if (err_cnt !== 8'(m_errcnt)) begin
      nerr++;
      $display("FAIL clr_alone: got %0d, required %0d", err_cnt, m_errcnt);
    end
  endtask

  task automatic test_enable_reset();
    logic [1:0] ab;
    en = 1'b0;
    for (int i = 0; i < 3; i++) step(fwd(m_ab), Hold);
    en = 1'b1;
    nvec++;
    if (dir !== 1'b1 || m_dir !== 1'b1 || sb.size() !== 0) begin
      nerr++;
      $display("FAIL enable_off: got dir %b pending %0d, required 1 0", dir, sb.size());
    end
    // Reset in the middle of a filter window.
    ab = fwd(m_ab);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (3) sample_cycle();
    reset_n = 1'b0;
    #1;
    nvec++;
    if ({up, down, err, dir} !== 4'b0000 || err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL midreset_outputs: got %b err_cnt %0d, required 0000 0",
               {up, down, err, dir}, err_cnt);
    end
    repeat (2) sample_cycle();
    reset_n = 1'b1;
    m_ab = ab;
    m_dir = 1'b0;
    m_errcnt = 0;
    repeat (Hold) sample_cycle();
    nvec++;
    if (dir !== 1'b0) begin
      nerr++;
      $display("FAIL reprime_dir: got %b, required 0", dir);
    end
    step(fwd(m_ab), Hold);
    nvec++;
    if (dir !== m_dir || sb.size() !== 0 || err_cnt !== 8'd0) begin
      nerr++;
      $display("FAIL reprime_step: got dir %b pending %0d err_cnt %0d, required %b 0 0",
               dir, sb.size(), err_cnt, m_dir);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_modes();
    test_glitch();
    test_errors();
    test_enable_reset();
    repeat (Hold) sample_cycle();
    nvec++;
    if (sb.size() !== 0) begin
      nerr++;
      $display("FAIL final_pending: got %0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
